// File: rtl/alu_status_stage_pkg.sv
// Shared ALU constants for the status stage: datapath width, status bit indices
// and the occupancy encoding of the output skid buffer.
package alu_status_stage_pkg;

    localparam int WIDTH       = 32;
    localparam int ST_NEG      = 0;
    localparam int ST_ZERO     = 1;
    localparam int ST_CARRY    = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_W        = 4;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer. MAIN always drives the output; SKID absorbs
// the beat accepted while MAIN is stalled, so in_ready can be fully registered.
module alu_skid_buf
    import alu_status_stage_pkg::*;
#(
    parameter int PW = 37
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_data
);

    occ_e          occ_reg, occ_next;
    logic [PW-1:0] main_reg, main_next;
    logic [PW-1:0] skid_reg, skid_next;
    logic          in_ready_reg, in_ready_next;
    logic          accept;
    logic          handoff;

    assign out_valid = (occ_reg != OCC_EMPTY);
    assign in_ready  = in_ready_reg;
    assign out_data  = main_reg;
    assign accept    = in_valid & in_ready_reg;
    assign handoff   = out_valid & out_ready;

    always_comb begin
        occ_next  = occ_reg;
        main_next = main_reg;
        skid_next = skid_reg;
        unique case (occ_reg)
            OCC_EMPTY: begin
                if (accept) begin
                    occ_next  = OCC_ONE;
                    main_next = in_data;
                end
            end
            OCC_ONE: begin
                if (accept && !handoff) begin
                    occ_next  = OCC_FULL;
                    skid_next = in_data;
                end else if (handoff && !accept) begin
                    occ_next  = OCC_EMPTY;
                end else if (accept && handoff) begin
                    main_next = in_data;
                end
            end
            OCC_FULL: begin
                // in_ready is low here, so no accept can coincide with the drain
                if (handoff) begin
                    occ_next  = OCC_ONE;
                    main_next = skid_reg;
                end
            end
            default: begin
                occ_next = OCC_EMPTY;
            end
        endcase
        in_ready_next = (occ_next != OCC_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg      <= OCC_EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            occ_reg      <= occ_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            in_ready_reg <= in_ready_next;
        end
    end

endmodule

// File: rtl/alu_status_stage.sv
// Registered ALU output stage: buffers {result, status, flag_we} beats and updates
// the architectural flags and sticky-flags registers on each downstream hand-off.
module alu_status_stage
    import alu_status_stage_pkg::*;
#(
    parameter int             WIDTH_P     = WIDTH,
    parameter logic [ST_W-1:0] STICKY_MASK = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH_P-1:0] in_result,
    input  logic [ST_W-1:0]   in_status,
    input  logic              in_flag_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH_P-1:0] out_result,
    output logic [ST_W-1:0]   out_status,
    output logic [ST_W-1:0]   flags,
    output logic [ST_W-1:0]   sticky,
    input  logic              clr_sticky
);

    localparam int PW = WIDTH_P + ST_W + 1;

    logic [PW-1:0]   in_payload;
    logic [PW-1:0]   out_payload;
    logic            out_flag_we;
    logic            handoff;
    logic [ST_W-1:0] flags_reg, flags_next;
    logic [ST_W-1:0] sticky_reg, sticky_next;

    assign in_payload = {in_flag_we, in_status, in_result};
    assign {out_flag_we, out_status, out_result} = out_payload;

    alu_skid_buf #(
        .PW (PW)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign handoff    = out_valid & out_ready;
    assign flags_next = (handoff && out_flag_we) ? out_status : flags_reg;

    // A hand-off's own bits survive a same-cycle clear; older bits do not
    genvar gi;
    generate
        for (gi = 0; gi < ST_W; gi++) begin : g_sticky
            assign sticky_next[gi] = STICKY_MASK[gi] &
                                     ((handoff & out_status[gi]) | (~clr_sticky & sticky_reg[gi]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg  <= '0;
            sticky_reg <= '0;
        end else begin
            flags_reg  <= flags_next;
            sticky_reg <= sticky_next;
        end
    end

    assign flags  = flags_reg;
    assign sticky = sticky_reg;

endmodule

// File: tb/tb_alu_status_stage.sv
// Scoreboard bench for alu_status_stage: beats are queued on acceptance and
// compared in order when handed off; flags/sticky follow a small bench model.
module tb_alu_status_stage;

    localparam logic [3:0] MASK = 4'b1000;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  s;
        logic        we;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic [3:0]  in_status = '0;
    logic        in_flag_we = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [3:0]  out_status;
    logic [3:0]  flags;
    logic [3:0]  sticky;
    logic        clr_sticky = 1'b0;

    int    errors = 0;
    int    checks = 0;
    beat_t q[$];
    logic [3:0] exp_flags = '0;
    logic [3:0] exp_sticky = '0;

    alu_status_stage #(
        .STICKY_MASK (MASK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_status  (in_status),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_status (out_status),
        .flags      (flags),
        .sticky     (sticky),
        .clr_sticky (clr_sticky)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic iv, input logic [31:0] r, input logic [3:0] s,
                         input logic we, input logic ordy, input logic clr);
        in_valid   = iv;
        in_result  = r;
        in_status  = s;
        in_flag_we = we;
        out_ready  = ordy;
        clr_sticky = clr;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (flags !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b want=0000", flags); end
        if (sticky !== 4'b0) begin errors++; $display("FAIL reset_sticky got=%b want=0000", sticky); end
        if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got=%h want=0", out_result); end
        $display("reset: out_valid=%b in_ready=%b flags=%b sticky=%b", out_valid, in_ready, flags, sticky);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] res [2];
        logic [3:0]  st [2];
        beat_t e;
        int n_out = 0;
        res[0] = 32'h0000_0000; st[0] = 4'b0010;
        res[1] = 32'hFFFF_FFFF; st[1] = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c < 2) drive(1'b1, res[c], st[c], 1'b0, 1'b1, 1'b0);
            else       drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got=%b want=1", c, in_ready); end
            if (c == 1 || c == 2) begin
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_latency c=%0d out_valid=%b want=1", c, out_valid); end
            end
            if (in_valid && in_ready) q.push_back('{r: in_result, s: in_status, we: in_flag_we});
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL stream_unexpected got=%h/%b want=none", out_result, out_status);
                end else begin
                    e = q.pop_front();
                    checks += 2;
                    if (out_result !== e.r) begin errors++; $display("FAIL stream_result got=%h want=%h", out_result, e.r); end
                    if (out_status !== e.s) begin errors++; $display("FAIL stream_status got=%b want=%b", out_status, e.s); end
                    if (e.we) exp_flags = e.s;
                    $display("stream: beat %h/%b handed off", out_result, out_status);
                end
            end
        end
        checks++;
        if (n_out != 2) begin errors++; $display("FAIL stream_count got=%0d want=2", n_out); end
    endtask

    task automatic test_backpressure();
        logic [31:0] res [3];
        beat_t e;
        int idx = 0;
        res[0] = 32'h1111_0001; res[1] = 32'h2222_0002; res[2] = 32'h3333_0003;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (idx < 3) drive(1'b1, res[idx], 4'(idx + 1), 1'b0, (c >= 4), 1'b0);
            else         drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            if (c == 2 || c == 3) begin
                checks += 2;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); end
                if (out_result !== res[0]) begin errors++; $display("FAIL bp_hold c=%0d got=%h want=%h", c, out_result, res[0]); end
            end
            if (in_valid && in_ready) begin
                q.push_back('{r: in_result, s: in_status, we: in_flag_we});
                idx++;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++; $display("FAIL bp_unexpected got=%h want=none", out_result);
                end else begin
                    e = q.pop_front();
                    checks += 2;
                    if (out_result !== e.r) begin errors++; $display("FAIL bp_result got=%h want=%h", out_result, e.r); end
                    if (out_status !== e.s) begin errors++; $display("FAIL bp_status got=%b want=%b", out_status, e.s); end
                    $display("backpressure: beat %h/%b handed off", out_result, out_status);
                end
            end
        end
        checks += 2;
        if (idx != 3) begin errors++; $display("FAIL bp_accepted got=%0d want=3", idx); end
        if (q.size() != 0) begin errors++; $display("FAIL bp_drain left=%0d want=0", q.size()); end
    endtask

    task automatic test_flags();
        beat_t e;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0)      drive(1'b1, 32'hFFFF_0000, 4'b0001, 1'b1, 1'b1, 1'b0);
            else if (c == 1) drive(1'b1, 32'h0000_0000, 4'b0010, 1'b0, 1'b1, 1'b0);
            else             drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            if (in_valid && in_ready) q.push_back('{r: in_result, s: in_status, we: in_flag_we});
            if (out_valid && out_ready && q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (out_status !== e.s) begin errors++; $display("FAIL flags_status got=%b want=%b", out_status, e.s); end
                if (e.we) exp_flags = e.s;
            end
        end
        checks += 2;
        if (flags !== exp_flags) begin errors++; $display("FAIL flags_model got=%b want=%b", flags, exp_flags); end
        if (flags !== 4'b0001) begin errors++; $display("FAIL flags_value got=%b want=0001", flags); end
        $display("flags: flags=%b", flags);
    endtask

    task automatic test_sticky();
        // columns: in_valid, clr_sticky, check-after flag, required sticky
        logic       iv  [8];
        logic       clr [8];
        logic       chk [8];
        logic [3:0] req [8];
        beat_t e;
        logic ho;
        iv  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        clr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        chk = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        req = '{4'b0, 4'b0, 4'b1000, 4'b0, 4'b0000, 4'b0, 4'b0, 4'b1000};
        exp_sticky = sticky;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (chk[c]) begin
                checks += 2;
                if (sticky !== exp_sticky) begin errors++; $display("FAIL sticky_model step=%0d got=%b want=%b", c, sticky, exp_sticky); end
                if (sticky !== req[c]) begin errors++; $display("FAIL sticky_value step=%0d got=%b want=%b", c, sticky, req[c]); end
                $display("sticky: step=%0d sticky=%b", c, sticky);
            end
            drive(iv[c], 32'h8000_0000, 4'b1000, 1'b0, 1'b1, clr[c]);
            if (in_valid && in_ready) q.push_back('{r: in_result, s: in_status, we: in_flag_we});
            ho = out_valid && out_ready;
            if (ho) begin
                e = q.pop_front();
                checks++;
                if (out_status !== e.s) begin errors++; $display("FAIL sticky_status got=%b want=%b", out_status, e.s); end
            end
            if (clr_sticky) exp_sticky = ho ? (e.s & MASK) : 4'b0;
            else if (ho)    exp_sticky = exp_sticky | (e.s & MASK);
        end
        @(negedge clk);
        checks++;
        if (sticky !== 4'b1000) begin errors++; $display("FAIL sticky_final got=%b want=1000", sticky); end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b1, 32'hA5A5_0000 + 32'(c), 4'b1001, 1'b1, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_full in_ready=%b want=0", in_ready); end
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b want=0", out_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got=%b want=1", in_ready); end
        if (flags !== 4'b0) begin errors++; $display("FAIL areset_flags got=%b want=0000", flags); end
        if (sticky !== 4'b0) begin errors++; $display("FAIL areset_sticky got=%b want=0000", sticky); end
        $display("async_reset: out_valid=%b in_ready=%b flags=%b", out_valid, in_ready, flags);
        q.delete();
        exp_flags = '0;
        exp_sticky = '0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_ghost c=%0d out_valid=%b want=0", c, out_valid); end
        end
        checks++;
        if (flags !== exp_flags) begin errors++; $display("FAIL areset_flags_after got=%b want=%b", flags, exp_flags); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flags();
        test_sticky();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
